ps2_verification: RTL and testbench
===================================

Name: ps2_verification

Overview:
- Board-level bring-up block: on each debounced press of a push button, it samples the 8 slide switches and transmits that byte once over a UART TX line (8N1, LSB first).
- Used to verify the serial link to the host before the PS/2 path is attached.
- Contains a button synchronizer, debouncer, rising-edge detector and UART transmitter FSM.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range ≥ 2.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable synchronized cycles required before the debounced button changes state (10 ms at 100 MHz); legal range ≥ 1.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- sw_i  input  8  slide switches; byte to transmit. Treated as quasi-static and sampled without a synchronizer at frame start.
- btn_i  input  1  raw push button, active-high, asynchronous/bouncy.
- TX_serial  output  1  UART transmit line, idle high.

Behaviour:
- Reset (async, active-high):
  - TX_serial = 1.
  - FSM = IDLE.
  - Synchronizer flops, debounced button and edge register = 0.
  - All counters = 0.
- Reset asserted mid-frame aborts the frame immediately; TX_serial goes high without waiting for a clock edge.
- Synchronizer: 2 flops on btn_i produce btn_sync.
- Debounce:
  - Counter clears whenever btn_sync equals btn_db.
  - Otherwise the counter increments each cycle.
  - When it reaches DEBOUNCE_CYCLES-1 while btn_sync still differs, btn_db takes btn_sync and the counter clears.
  - Any glitch back to btn_db before then clears the counter.
- Edge detect: press = btn_db & ~btn_db_q. It is a 1-cycle pulse; releases generate nothing.
- UART FSM:
  - IDLE: TX_serial = 1. On press, latch sw_i into shift register, clear bit counter and baud counter, go to START.
  - START: TX_serial = 0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: TX_serial = shift[0]. Each bit is held CLKS_PER_BIT cycles, then shift right. After 8 bits, go to STOP.
  - STOP: TX_serial = 1 for CLKS_PER_BIT cycles, then IDLE.
- Timing:
  - Full frame = 10*CLKS_PER_BIT cycles.
  - TX_serial is registered. The start bit appears on the first clock edge after the cycle in which press is high.
- Presses arriving while not in IDLE are dropped, not queued.
- A press in the same cycle that STOP→IDLE occurs is also dropped. The next press is accepted from IDLE.
- Changes to sw_i after latching do not affect the frame in progress.
- Baud counter width: clog2(CLKS_PER_BIT). Debounce counter width: clog2(DEBOUNCE_CYCLES+1).

Test Plan (bench overrides CLKS_PER_BIT=4, DEBOUNCE_CYCLES=8, 10 ns clock):
- Reset only: reset_i=1 then released, btn_i=0 for 200 cycles -> TX_serial held 1 throughout.
- sw_i=8'hA5, btn_i held high 50 cycles -> exactly one frame; TX_serial bit sequence (4 cycles each) is 0,1,0,1,0,0,1,0,1,1; idle high afterwards.
- Bounce: btn_i toggled every 3 cycles for 30 cycles, then low -> no frame; TX_serial stays 1.
- Second press during the frame (sw_i=8'h3C, press, re-press at cycle 20 of the frame after releasing) -> only one frame, carrying 8'h3C; the re-press is ignored. sw_i changed to 8'hFF mid-frame does not alter the data bits.
- Reset mid-frame: assert reset_i during DATA bit 3 -> TX_serial = 1 immediately (asynchronously). After release with btn_i=0, no further transmission. A new press then sends a full frame from the start bit.
- Back-to-back: sw_i=8'h00, press, wait for frame completion, release, press again -> two identical frames 0,0,0,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/ps2_verification.sv
// Switch-to-UART bring-up block. Each debounced button press sends the 8 slide
// switches once as an 8N1 frame (LSB first) so the host serial link can be checked.
module ps2_verification #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] sw_i,
  input  logic       btn_i,
  output logic       TX_serial
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SYNC_STAGES = 2;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  // ---------------------------------------------------------------------------
  // Button conditioning: synchronizer shift register, debouncer, rising edge
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   btn_sync;
  logic                   btn_db;
  logic                   btn_db_q;
  logic [DB_W-1:0]        db_cnt;
  logic                   press;

  assign btn_sync = sync_pipe[SYNC_STAGES-1];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) sync_pipe <= '0;
    else         sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], btn_i};
  end

  // Counter only runs while the synchronized input disagrees with the
  // debounced level, so any bounce back to the old level restarts the wait.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else if (btn_sync == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_db <= btn_sync;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) btn_db_q <= 1'b0;
    else         btn_db_q <= btn_db;
  end

  assign press = btn_db & ~btn_db_q;

  // ---------------------------------------------------------------------------
  // UART transmitter
  // ---------------------------------------------------------------------------
  tx_state_e         state;
  logic [7:0]        shift;
  logic [2:0]        bit_cnt;
  logic [BAUD_W-1:0] baud_cnt;
  logic              baud_done;

  assign baud_done = (baud_cnt == BAUD_LAST);

  // TX_serial is loaded with the level of the state being entered, so the
  // line changes on the same edge as the state and every bit lasts exactly
  // CLKS_PER_BIT cycles. The async reset drives the line idle immediately.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      baud_cnt  <= '0;
      TX_serial <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          TX_serial <= 1'b1;
          if (press) begin
            shift     <= sw_i;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
            TX_serial <= 1'b0;
            state     <= START;
          end
        end

        START: begin
          if (baud_done) begin
            baud_cnt  <= '0;
            TX_serial <= shift[0];
            state     <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              TX_serial <= 1'b1;
              state     <= STOP;
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              shift     <= {1'b0, shift[7:1]};
              TX_serial <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          // A press coinciding with this exit is deliberately not looked at.
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          TX_serial <= 1'b1;
          baud_cnt  <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_verification.sv
// Scoreboarded bench for ps2_verification: stimulus pushes expected frames,
// a UART sampling monitor pops and compares every frame seen on TX_serial.
module tb_ps2_verification;
  localparam int CPB = 4;
  localparam int DEB = 8;
  localparam int FRAME_CYC = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw  = 8'h00;
  logic       btn = 1'b0;
  logic       tx;

  ps2_verification #(.CLKS_PER_BIT(CPB), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk_i    (clk),
    .reset_i  (rst),
    .sw_i     (sw),
    .btn_i    (btn),
    .TX_serial(tx)
  );

  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_pass    = 0;
  int frames_rx = 0;
  logic [9:0] sb_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Frame pattern bit i is the i-th bit on the wire (start first).
  function automatic logic [FRAME_CYC-1:0] expand(input logic [9:0] f);
    logic [FRAME_CYC-1:0] w;
    for (int i = 0; i < FRAME_CYC; i++) w[i] = f[i / CPB];
    return w;
  endfunction

  initial begin : monitor
    logic                 prev;
    logic                 coll;
    int                   idx;
    logic [FRAME_CYC-1:0] got;
    logic [9:0]           ef;
    prev = 1'b1; coll = 1'b0; idx = 0; got = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        coll = 1'b0;
        prev = 1'b1;
      end else begin
        if (coll) begin
          got[idx] = tx;
          idx++;
        end else if (prev && tx === 1'b0) begin
          coll = 1'b1;
          got  = '0;
          idx  = 1;
        end
        if (coll && idx == FRAME_CYC) begin
          coll = 1'b0;
          frames_rx++;
          if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_frame: got waveform %h expected no frame", got);
          end else begin
            ef = sb_q.pop_front();
            check("frame_waveform", 64'(got), 64'(expand(ef)));
          end
        end
        prev = tx;
      end
    end
  end

  task automatic idle_check(input string name, input int n);
    int lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check(name, 64'(lows), 64'd0);
  endtask

  task automatic wait_frames(input string name, input int target, input int budget);
    int k = 0;
    while (frames_rx < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 64'(frames_rx), 64'(target));
  endtask

  task automatic wait_tx_low(input string name, input int budget);
    int k = 0;
    bit ok = 0;
    while (k < budget && !ok) begin
      @(negedge clk);
      k++;
      if (tx === 1'b0) ok = 1;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL %s: got no start bit within %0d cycles, expected one", name, budget);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // Reset and quiet idle
    repeat (3) @(negedge clk);
    check("reset_tx_high", 64'(tx), 64'd1);
    rst = 1'b0;
    idle_check("reset_idle", 200);

    // Single press, long hold -> one A5 frame
    sw = 8'hA5;
    sb_q.push_back({1'b1, 8'hA5, 1'b0});
    btn = 1'b1;
    repeat (50) @(negedge clk);
    btn = 1'b0;
    wait_frames("a5_frame_count", 1, 200);
    idle_check("a5_idle_after", 60);

    // Bouncing input never stable long enough
    for (int i = 0; i < 10; i++) begin
      btn = ~btn;
      repeat (3) @(negedge clk);
    end
    btn = 1'b0;
    idle_check("bounce_idle", 100);
    check("bounce_frame_count", 64'(frames_rx), 64'd1);

    // Re-press mid-frame is dropped; sw change after latch is ignored
    sw = 8'h3C;
    sb_q.push_back({1'b1, 8'h3C, 1'b0});
    btn = 1'b1;
    wait_tx_low("repress_start", 100);
    @(negedge clk);
    btn = 1'b0;
    repeat (9) @(negedge clk);
    sw = 8'hFF;
    repeat (10) @(negedge clk);
    btn = 1'b1;
    wait_frames("repress_frame_count", 2, 200);
    repeat (10) @(negedge clk);
    btn = 1'b0;
    idle_check("repress_idle_after", 80);
    check("repress_single_frame", 64'(frames_rx), 64'd2);

    // Async reset during data bit 3 (bit 3 of F0 is 0)
    sw = 8'hF0;
    btn = 1'b1;
    wait_tx_low("reset_mid_start", 100);
    @(negedge clk);
    btn = 1'b0;
    repeat (16) @(negedge clk);
    check("pre_reset_bit3_low", 64'(tx), 64'd0);
    #1 rst = 1'b1;
    #1 check("async_reset_tx_high", 64'(tx), 64'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_check("post_reset_idle", 100);
    check("post_reset_frame_count", 64'(frames_rx), 64'd2);
    sb_q.push_back({1'b1, 8'hF0, 1'b0});
    btn = 1'b1;
    repeat (30) @(negedge clk);
    btn = 1'b0;
    wait_frames("post_reset_new_frame", 3, 200);

    // Back-to-back 00 frames
    repeat (20) @(negedge clk);
    sw = 8'h00;
    sb_q.push_back({1'b1, 8'h00, 1'b0});
    btn = 1'b1;
    wait_frames("b2b_first", 4, 200);
    btn = 1'b0;
    repeat (20) @(negedge clk);
    sb_q.push_back({1'b1, 8'h00, 1'b0});
    btn = 1'b1;
    wait_frames("b2b_second", 5, 200);
    btn = 1'b0;
    idle_check("final_idle", 60);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
